// File: rtl/instr_fetch_ctrl.sv
`timescale 1ns/1ps
// Fetch/decode sequencer: PC, BRAM port-A addressing, instruction register, decode to datapath controls.
// Each instruction takes four cycles from an accepted step; step is sampled only in FETCH and never queued.
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [3:0]            regA,
  output logic [3:0]            regB,
  output logic [3:0]            alu_op,
  output logic                  reg_imm,
  output logic [15:0]           imm_val,
  output logic                  write_enable,
  output logic                  halted,
  output logic [15:0]           instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [15:0]           ir_q;
  logic [15:0]           cnt_q;
  logic                  halted_q;
  logic                  we_q;

  logic                  is_rtype;
  logic [3:0]            op;
  logic                  op_writes;

  assign is_rtype = (ir_q[15:12] == 4'h0);
  assign op       = is_rtype ? ir_q[7:4] : ir_q[15:12];

  // CMP (1011) and any unlisted code retire as NOPs.
  always_comb begin
    op_writes = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hD: op_writes = 1'b1;
      default:                            op_writes = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= START_ADDR;
      ir_q     <= 16'h0000;
      cnt_q    <= 16'h0000;
      halted_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          we_q <= 1'b0;
          if (step) state_q <= S_WAIT;
        end
        S_WAIT: begin
          ir_q    <= instr;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (ir_q == 16'h0000) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            // Registered strobe so it is high for exactly the EXEC cycle.
            we_q    <= op_writes;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          we_q    <= 1'b0;
          pc_q    <= pc_q + 1'b1;
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          we_q <= 1'b0;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign regA         = ir_q[11:8];
  assign regB         = ir_q[3:0];
  assign alu_op       = op;
  assign reg_imm      = ~is_rtype;
  assign imm_val      = {{8{ir_q[7]}}, ir_q[7:0]};
  assign write_enable = we_q;
  assign halted       = halted_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for instr_fetch_ctrl: directed program plus a long random program checked
// against a per-instruction reference model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [15:0] instr;
  logic [9:0]  pc;
  logic [3:0]  regA, regB, alu_op;
  logic        reg_imm;
  logic [15:0] imm_val;
  logic        write_enable;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] mem [1024];
  int          tests = 0;
  int          fails = 0;

  logic [9:0]  m_pc;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  // Synchronous-read BRAM port A
  always @(posedge clk) instr <= mem[pc];

  instr_fetch_ctrl #(.ADDR_WIDTH(10), .START_ADDR(10'd0)) dut (
    .clk(clk), .rst(rst), .step(step), .instr(instr), .pc(pc),
    .regA(regA), .regB(regB), .alu_op(alu_op), .reg_imm(reg_imm),
    .imm_val(imm_val), .write_enable(write_enable), .halted(halted),
    .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_op(input logic [15:0] w);
    return (w[15:12] == 4'h0) ? w[7:4] : w[15:12];
  endfunction

  function automatic logic exp_writes(input logic [15:0] w);
    logic [3:0] o;
    o = exp_op(w);
    return (o == 4'b0001) || (o == 4'b0010) || (o == 4'b0011) ||
           (o == 4'b0101) || (o == 4'b1001) || (o == 4'b1101);
  endfunction

  task automatic do_reset();
    rst  = 1'b0;
    step = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_pc", pc, 0);
      chk("rst_we", write_enable, 0);
    end
    chk("rst_halted", halted, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_aluop", alu_op, 0);
    chk("rst_regs", {regA, regB, 3'b000, reg_imm}, 0);
    chk("rst_imm", imm_val, 0);
    step = 1'b0;
    rst  = 1'b1;
    m_pc  = 10'd0;
    m_cnt = 16'd0;
  endtask

  task automatic idle(input int n);
    step = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_pc", pc, m_pc);
      chk("idle_we", write_enable, 0);
    end
  endtask

  // One instruction from an accepted step; called at a negedge while the DUT sits in FETCH.
  task automatic run_instr(input bit abort_in_exec);
    logic [15:0] w;
    w    = mem[m_pc];
    step = 1'b1;
    @(negedge clk);
    chk("wait_pc", pc, m_pc);
    chk("wait_we", write_enable, 0);
    step = 1'($urandom);
    @(negedge clk);
    chk("dec_regA", regA, w[11:8]);
    chk("dec_regB", regB, w[3:0]);
    chk("dec_aluop", alu_op, exp_op(w));
    chk("dec_regimm", reg_imm, w[15:12] != 4'h0);
    chk("dec_imm", imm_val, {{8{w[7]}}, w[7:0]});
    chk("dec_we", write_enable, 0);
    chk("dec_pc", pc, m_pc);
    step = 1'($urandom);
    @(negedge clk);
    if (w == 16'h0000) begin
      step = 1'b0;
      chk("halt_flag", halted, 1);
      chk("halt_we", write_enable, 0);
      return;
    end
    chk("exec_we", write_enable, exp_writes(w));
    chk("exec_halted", halted, 0);
    if (abort_in_exec) begin
      rst = 1'b0;
      #1;
      chk("abort_we", write_enable, 0);
      chk("abort_pc", pc, 0);
      chk("abort_cnt", instr_count, 0);
      @(negedge clk);
      rst   = 1'b1;
      m_pc  = 10'd0;
      m_cnt = 16'd0;
      return;
    end
    step = 1'b0;
    @(negedge clk);
    m_pc = m_pc + 10'd1;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    chk("post_pc", pc, m_pc);
    chk("post_cnt", instr_count, m_cnt);
    chk("post_we", write_enable, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0152;
    mem[1] = 16'h53FF;
    mem[2] = 16'h04B5;
    mem[3] = 16'h0000;
    do_reset();

    idle(20);
    run_instr(1'b0);
    run_instr(1'b0);
    run_instr(1'b0);
    chk("cmp_pc", pc, 3);
    run_instr(1'b0);
    repeat (5) begin
      step = 1'b1;
      @(negedge clk);
      chk("halt_pc", pc, 3);
      chk("halt_cnt", instr_count, 3);
      chk("halt_hold", halted, 1);
      chk("halt_nowe", write_enable, 0);
    end
    do_reset();
    chk("rehalt_clear", halted, 0);

    idle(2);
    run_instr(1'b1);
    chk("abort_resume_pc", pc, 0);

    // Long random program with no halt word; crosses the PC wrap from 1023 to 0.
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == 16'h0000) mem[i] = 16'h0D01;
    end
    do_reset();
    for (int n = 0; n < 1100; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      run_instr(1'b0);
    end
    chk("final_cnt", instr_count, 1100);
    chk("final_pc", pc, 1100 % 1024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
